// File: rtl/imem_read_port.sv
// Word-addressed 64-bit memory: combinational read port for instruction fetch, clocked byte-masked write port.
// Optional range checking (zero data, dropped writes, sticky oob_err) via IMEM_READ_PORT_BOUNDS_CHECK_EN.
module imem_read_port #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int          DEPTH     = 4096,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] raddr,
    input  logic        ren,
    output logic [63:0] rdata,
    input  logic        wen,
    input  logic [63:0] waddr,
    input  logic [63:0] wdata,
    input  logic [7:0]  wmask,
    output logic        oob_err,
    output logic [31:0] rd_count
);
    localparam int AW = $clog2(DEPTH);

    logic [63:0]    r_mem [DEPTH];
    logic [31:0]    r_rd_count;
    logic [63:0]    w_roff;
    logic [63:0]    w_woff;
    logic [AW-1:0]  w_ridx;
    logic [AW-1:0]  w_widx;
    logic           w_rd_ok;
    logic           w_wr_ok;

    // Unsigned difference: addresses below BASE_ADDR wrap to huge offsets and fail the range test.
    assign w_roff = raddr - BASE_ADDR;
    assign w_woff = waddr - BASE_ADDR;
    assign w_ridx = w_roff[AW+2:3];
    assign w_widx = w_woff[AW+2:3];

`ifdef IMEM_READ_PORT_BOUNDS_CHECK_EN
    logic r_oob;
    logic w_unused_lo;

    assign w_rd_ok     = (w_roff[63:AW+3] == '0);
    assign w_wr_ok     = (w_woff[63:AW+3] == '0);
    assign w_unused_lo = ^{w_roff[2:0], w_woff[2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oob <= 1'b0;
        end else if ((ren && !w_rd_ok) || (wen && !w_wr_ok)) begin
            r_oob <= 1'b1;
        end
    end

    assign oob_err = r_oob;
`else
    logic w_unused_bits;

    // Without checking, the high offset bits are dropped so addresses alias modulo DEPTH.
    assign w_rd_ok       = 1'b1;
    assign w_wr_ok       = 1'b1;
    assign w_unused_bits = ^{w_roff[63:AW+3], w_woff[63:AW+3], w_roff[2:0], w_woff[2:0]};
    assign oob_err       = 1'b0;
`endif

    assign rdata = (ren && w_rd_ok) ? r_mem[w_ridx] : 64'h0;

    // Array is not cleared by reset; the reset branch only suppresses writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else if (wen && w_wr_ok) begin
            for (int i = 0; i < 8; i++) begin
                if (wmask[i]) r_mem[w_widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= 32'h0;
        end else if (ren) begin
            r_rd_count <= r_rd_count + 32'h1;
        end
    end

    assign rd_count = r_rd_count;
endmodule

// File: tb/tb_imem_read_port.sv
// Randomized self-checking bench for imem_read_port against a sparse word-map reference model.
module tb_imem_read_port;
    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          NWORD = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] raddr, waddr, wdata, rdata;
    logic        ren, wen, oob_err;
    logic [7:0]  wmask;
    logic [31:0] rd_count;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] m_mem [longint];
    logic [31:0] exp_cnt;
    logic        exp_oob;

    imem_read_port dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .ren(ren), .rdata(rdata),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wmask(wmask),
        .oob_err(oob_err), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

`ifdef IMEM_READ_PORT_BOUNDS_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    // Returns word index of a byte address, or -1 when out of range with checking on.
    function automatic longint widx(input logic [63:0] a);
        if (CHECK_EN) begin
            if (a < BASE || ((a - BASE) / 8) >= DEPTH) return -1;
            return longint'((a - BASE) / 8);
        end
        return longint'(((a - BASE) / 8) % DEPTH);
    endfunction

    function automatic logic [63:0] exp_rdata();
        longint k;
        if (!ren) return 64'h0;
        k = widx(raddr);
        if (k < 0) return 64'h0;
        if (!m_mem.exists(k)) return 64'hx;
        return m_mem[k];
    endfunction

    // Called at negedge with inputs settled: check comb read, clock, update model, check state.
    task automatic step(input string tag);
        logic [63:0] er;
        longint      k;
        #1;
        er = exp_rdata();
        if (!$isunknown(er)) chk({tag, "_rdata"}, rdata, er);
        @(posedge clk);
        if (rst_n) begin
            if (ren) exp_cnt = exp_cnt + 1;
            if (ren && widx(raddr) < 0) exp_oob = 1'b1;
            if (wen) begin
                k = widx(waddr);
                if (k < 0) exp_oob = 1'b1;
                else for (int i = 0; i < 8; i++)
                    if (wmask[i]) begin
                        if (!m_mem.exists(k)) m_mem[k] = 64'h0;
                        m_mem[k][8*i +: 8] = wdata[8*i +: 8];
                    end
            end
        end
        #1;
        chk({tag, "_cnt"}, {32'h0, rd_count}, {32'h0, exp_cnt});
        chk({tag, "_oob"}, {63'h0, oob_err}, {63'h0, exp_oob});
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic [63:0] ra, input logic w,
                         input logic [63:0] wa, input logic [63:0] wd, input logic [7:0] wm);
        ren = r; raddr = ra; wen = w; waddr = wa; wdata = wd; wmask = wm;
    endtask

    initial begin
        exp_cnt = 0; exp_oob = 0;
        rst_n = 1'b0;
        drive(1'b0, BASE, 1'b0, BASE, 64'h0, 8'h0);
        #2;
        chk("reset_cnt", {32'h0, rd_count}, 64'h0);
        chk("reset_oob", {63'h0, oob_err}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill the first NWORD words; word0 holds two RISC-V instructions, word2 is zero.
        for (int i = 0; i < NWORD; i++) begin
            drive(1'b0, BASE, 1'b1, BASE + 64'(i*8),
                  (i == 0) ? 64'h0000_0013_0000_0093 : (i == 2) ? 64'h0 : {$urandom, $urandom}, 8'hFF);
            step("fill");
        end

        drive(1'b1, BASE, 1'b0, BASE, 64'h0, 8'h0);
        #1 chk("fetch_w0", rdata, 64'h0000_0013_0000_0093);
        step("fetch0");
        drive(1'b1, BASE + 64'h4, 1'b0, BASE, 64'h0, 8'h0);
        #1 chk("fetch_w0_lowbits", rdata, 64'h0000_0013_0000_0093);
        step("fetch4");

        drive(1'b1, BASE + 64'h10, 1'b1, BASE + 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F);
        #1 chk("mask_before", rdata, 64'h0);
        step("mask");
        drive(1'b1, BASE + 64'h10, 1'b0, BASE, 64'h0, 8'h0);
        #1 chk("mask_after", rdata, 64'h0000_0000_CAFE_F00D);
        step("mask_rd");

        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 64'({$urandom, $urandom}), 1'b0, BASE, 64'h0, 8'h0);
            #1 chk("ren0_zero", rdata, 64'h0);
            step("ren0");
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, BASE + 64'(i*8), 1'b0, BASE, 64'h0, 8'h0);
            step("ren1");
        end

        // Random traffic inside the filled window; aliasing addresses only when unchecked.
        for (int n = 0; n < 400; n++) begin
            logic [63:0] ra, wa;
            ra = BASE + 64'($urandom_range(0, NWORD*8-1));
            wa = BASE + 64'($urandom_range(0, NWORD*8-1));
            if (!CHECK_EN && $urandom_range(0, 3) == 0) ra = ra + 64'(DEPTH*8*$urandom_range(1, 3));
            if (!CHECK_EN && $urandom_range(0, 3) == 0) wa = wa + 64'(DEPTH*8*$urandom_range(1, 3));
            drive(1'($urandom), ra, 1'($urandom), wa, {$urandom, $urandom}, 8'($urandom));
            step("rand");
        end

`ifdef IMEM_READ_PORT_BOUNDS_CHECK_EN
        drive(1'b1, 64'h7FFF_FFF8, 1'b0, BASE, 64'h0, 8'h0);
        #1 chk("oob_rd_zero", rdata, 64'h0);
        step("oob_rd");
        drive(1'b0, BASE, 1'b1, BASE + 64'(DEPTH*8), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        step("oob_wr");
        drive(1'b1, BASE + 64'(DEPTH*8 - 8), 1'b0, BASE, 64'h0, 8'h0);
        #1 chk("oob_last_in_range", {63'h0, oob_err}, 64'h1);
        step("last_word");
`else
        drive(1'b0, BASE, 1'b1, BASE, 64'h1234, 8'hFF);
        step("alias_wr");
        drive(1'b1, BASE + 64'h8000, 1'b0, BASE, 64'h0, 8'h0);
        #1 chk("alias_rd", rdata, 64'h1234);
        step("alias");
        drive(1'b1, 64'h7FFF_FFF8, 1'b0, BASE, 64'h0, 8'h0);
        step("below_base");
        chk("oob_tied", {63'h0, oob_err}, 64'h0);
`endif

        // Asynchronous reset in mid-cycle, memory survives, writes blocked while low.
        drive(1'b1, BASE + 64'h18, 1'b0, BASE, 64'h0, 8'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", {32'h0, rd_count}, 64'h0);
        chk("async_rst_oob", {63'h0, oob_err}, 64'h0);
        chk("rst_mem_kept", rdata, m_mem[3]);
        exp_cnt = 0; exp_oob = 0;
        @(negedge clk);
        drive(1'b1, BASE + 64'h18, 1'b1, BASE + 64'h18, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF);
        step("rst_wr");
        chk("rst_wr_blocked", rdata, m_mem[3]);
        rst_n = 1'b1;
        step("post_rst_wr");
        chk("post_rst_word", rdata, 64'hA5A5_5A5A_0F0F_F0F0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
